// File: rtl/matvec_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : matvec_pkg
//  Description : Shared definitions for the matrix-vector engine: MMIO word
//                addresses, FSM state encoding, the per-job configuration
//                record and the configuration-address lookup.
//  Revision    : 1.0 - initial release
// ============================================================================
package matvec_pkg;

    // Width of each captured configuration field (pointers and dimensions)
    localparam int unsigned C_CFG_PTR_W = 32;
    localparam int unsigned C_CFG_DIM_W = 32;

    // MMIO word addresses
    localparam logic [31:0] C_MATVEC_A_IN  = 32'h0000_0300;
    localparam logic [31:0] C_MATVEC_B_IN  = 32'h0000_0400;
    localparam logic [31:0] C_MATVEC_C_OUT = 32'h0000_0500;
    localparam logic [31:0] C_DIM_M        = 32'h0000_0600;
    localparam logic [31:0] C_DIM_N        = 32'h0000_0700;
    localparam logic [31:0] C_MATVEC_FLAG  = 32'h0000_0B00;

    typedef enum logic [2:0] {
        POLL = 3'd0,
        CHK  = 3'd1,
        CFG  = 3'd2,
        ROW  = 3'd3,
        MAC  = 3'd4,
        WR_C = 3'd5,
        CLR  = 3'd6,
        DONE = 3'd7
    } state_t;

    // Job configuration, latched once per job
    typedef struct packed {
        logic [C_CFG_PTR_W-1:0] a_ptr;
        logic [C_CFG_PTR_W-1:0] b_base;
        logic [C_CFG_PTR_W-1:0] c_ptr;
        logic [C_CFG_DIM_W-1:0] m;
        logic [C_CFG_DIM_W-1:0] n;
    } cfg_t;

    // Register address fetched in configuration step idx (0..4)
    function automatic logic [31:0] cfg_addr(input logic [2:0] idx);
        case (idx)
            3'd0:    cfg_addr = C_MATVEC_A_IN;
            3'd1:    cfg_addr = C_MATVEC_B_IN;
            3'd2:    cfg_addr = C_MATVEC_C_OUT;
            3'd3:    cfg_addr = C_DIM_M;
            default: cfg_addr = C_DIM_N;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/matvec_mac.sv
`default_nettype none
// ============================================================================
//  Module      : matvec_mac
//  Description : Registered signed multiply-accumulate. The signed product of
//                a and b is sign-extended to ACC_WIDTH and added to the
//                accumulator with wrap-around.
//  Ports       : clk, rst_n    - clock, async active-low reset
//                clr           - synchronous accumulator clear (wins over en)
//                en            - accumulate a*b this cycle
//                a, b          - signed DATA_WIDTH operands
//                acc           - accumulator value
//  Revision    : 1.0 - initial release
// ============================================================================
module matvec_mac #(
    parameter int DATA_WIDTH = 32,
    parameter int ACC_WIDTH  = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [ACC_WIDTH-1:0]  acc
);

    logic signed [2*DATA_WIDTH-1:0] w_prod;
    logic        [ACC_WIDTH-1:0]    w_prod_ext;
    logic        [ACC_WIDTH-1:0]    r_acc;

    assign w_prod = $signed(a) * $signed(b);

    generate
        if (ACC_WIDTH > 2 * DATA_WIDTH) begin : g_sext
            assign w_prod_ext = {{(ACC_WIDTH - 2 * DATA_WIDTH){w_prod[2*DATA_WIDTH-1]}}, w_prod};
        end else begin : g_exact
            assign w_prod_ext = w_prod[ACC_WIDTH-1:0];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (clr) begin
            r_acc <= '0;
        end else if (en) begin
            r_acc <= r_acc + w_prod_ext;
        end
    end

    assign acc = r_acc;

endmodule
`default_nettype wire

// File: rtl/matvec_engine.sv
`default_nettype none
// ============================================================================
//  Module      : matvec_engine
//  Description : Bus initiator that polls MATVEC_Flag, fetches the job
//                configuration, computes C[i] = sum_j A[i*N+j]*B[j] for i<M,
//                writes each C[i] back and finally clears the flag.
//  Ports       : clk, rst_n    - clock, async active-low reset
//                en            - polling enable (only looked at in POLL)
//                mem_addr      - word address to memory-map port B
//                mem_wdata     - write data
//                mem_we        - write strobe, one cycle per write
//                mem_rdata     - read data, valid the cycle after the
//                                address is issued
//                busy          - high from flag detect through flag clear
//                done          - one-cycle pulse after the flag-clear write
//  Revision    : 1.0 - initial release
// ============================================================================
module matvec_engine
    import matvec_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int ACC_WIDTH  = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy,
    output logic                  done
);

    state_t                  r_state;
    logic [2:0]              r_cfg_idx;
    cfg_t                    r_cfg;
    logic [ADDR_WIDTH-1:0]   r_a_ptr;
    logic [ADDR_WIDTH-1:0]   r_b_ptr;
    logic [ADDR_WIDTH-1:0]   r_c_ptr;
    logic [C_CFG_DIM_W-1:0]  r_row;
    logic [C_CFG_DIM_W-1:0]  r_j;
    logic                    r_phase;       // 0: A-issue/accumulate, 1: B-issue
    logic [DATA_WIDTH-1:0]   r_a_reg;
    logic [ADDR_WIDTH-1:0]   r_mem_addr;
    logic [DATA_WIDTH-1:0]   r_mem_wdata;
    logic                    r_mem_we;
    logic                    r_busy;
    logic                    r_done;

    logic                    w_mac_clr;
    logic                    w_mac_en;
    logic [ACC_WIDTH-1:0]    w_acc;
    logic                    w_unused_acc_hi;

    // Accumulate on every A-issue cycle except the first of a row (no B data
    // has arrived yet), and on the final drain cycle (j == N).
    assign w_mac_clr = (r_state == ROW);
    assign w_mac_en  = (r_state == MAC) && !r_phase && (r_j != '0);

    matvec_mac #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_mac_clr),
        .en    (w_mac_en),
        .a     (r_a_reg),
        .b     (mem_rdata),
        .acc   (w_acc)
    );

    // Only the low word of the accumulator is written back
    assign w_unused_acc_hi = ^w_acc[ACC_WIDTH-1:DATA_WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= POLL;
            r_cfg_idx   <= '0;
            r_cfg       <= '0;
            r_a_ptr     <= '0;
            r_b_ptr     <= '0;
            r_c_ptr     <= '0;
            r_row       <= '0;
            r_j         <= '0;
            r_phase     <= 1'b0;
            r_a_reg     <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_we    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_mem_we <= 1'b0;
            r_done   <= 1'b0;

            case (r_state)
                POLL: begin
                    if (en) begin
                        r_mem_addr <= ADDR_WIDTH'(C_MATVEC_FLAG);
                        r_state    <= CHK;
                    end
                end

                CHK: begin
                    if (mem_rdata[0]) begin
                        r_busy    <= 1'b1;
                        r_cfg_idx <= '0;
                        r_state   <= CFG;
                    end else begin
                        r_state   <= POLL;
                    end
                end

                // Pipelined config fetch: address for step k is issued in
                // cycle k, its data is captured in cycle k+1.
                CFG: begin
                    if (r_cfg_idx <= 3'd4) begin
                        r_mem_addr <= ADDR_WIDTH'(cfg_addr(r_cfg_idx));
                    end
                    case (r_cfg_idx)
                        3'd1: r_cfg.a_ptr  <= C_CFG_PTR_W'(mem_rdata);
                        3'd2: r_cfg.b_base <= C_CFG_PTR_W'(mem_rdata);
                        3'd3: r_cfg.c_ptr  <= C_CFG_PTR_W'(mem_rdata);
                        3'd4: r_cfg.m      <= C_CFG_DIM_W'(mem_rdata);
                        3'd5: begin
                            r_cfg.n <= C_CFG_DIM_W'(mem_rdata);
                            r_a_ptr <= ADDR_WIDTH'(r_cfg.a_ptr);
                            r_c_ptr <= ADDR_WIDTH'(r_cfg.c_ptr);
                            r_row   <= '0;
                            r_state <= (r_cfg.m == '0) ? CLR : ROW;
                        end
                        default: ;
                    endcase
                    r_cfg_idx <= r_cfg_idx + 3'd1;
                end

                ROW: begin
                    r_b_ptr <= ADDR_WIDTH'(r_cfg.b_base);
                    r_j     <= '0;
                    r_phase <= 1'b0;
                    r_state <= (r_cfg.n == '0) ? WR_C : MAC;
                end

                // a_ptr is never rewound, so consecutive rows walk A linearly
                MAC: begin
                    if (!r_phase) begin
                        if (r_j == r_cfg.n) begin
                            r_state <= WR_C;
                        end else begin
                            r_mem_addr <= r_a_ptr;
                            r_a_ptr    <= r_a_ptr + ADDR_WIDTH'(1);
                            r_phase    <= 1'b1;
                        end
                    end else begin
                        r_mem_addr <= r_b_ptr;
                        r_b_ptr    <= r_b_ptr + ADDR_WIDTH'(1);
                        r_a_reg    <= mem_rdata;
                        r_j        <= r_j + C_CFG_DIM_W'(1);
                        r_phase    <= 1'b0;
                    end
                end

                WR_C: begin
                    r_mem_addr  <= r_c_ptr;
                    r_mem_wdata <= w_acc[DATA_WIDTH-1:0];
                    r_mem_we    <= 1'b1;
                    r_c_ptr     <= r_c_ptr + ADDR_WIDTH'(1);
                    r_row       <= r_row + C_CFG_DIM_W'(1);
                    r_state     <= (r_row + C_CFG_DIM_W'(1) == r_cfg.m) ? CLR : ROW;
                end

                CLR: begin
                    r_mem_addr  <= ADDR_WIDTH'(C_MATVEC_FLAG);
                    r_mem_wdata <= '0;
                    r_mem_we    <= 1'b1;
                    r_state     <= DONE;
                end

                DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= POLL;
                end

                default: r_state <= POLL;
            endcase
        end
    end

    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_we    = r_mem_we;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_matvec_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_matvec_engine
//  Description : Self-checking bench for matvec_engine. A word-addressed
//                memory with combinational read sits on port B; jobs are
//                described by a vector table plus random jobs whose results
//                come from a plain-arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_matvec_engine;

    localparam int DW = 32;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_we;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    matvec_engine #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .ACC_WIDTH  (64)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .done      (done)
    );

    // ---------------- memory model ----------------
    logic [31:0] mem [0:65535];
    logic        tb_we = 1'b0;
    logic [15:0] tb_waddr = '0;
    logic [31:0] tb_wdata = '0;
    logic        unused_addr_hi;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;
    wr_t wr_log[$];

    assign mem_rdata      = mem[mem_addr[15:0]];
    assign unused_addr_hi = ^mem_addr[AW-1:16];

    always @(posedge clk) begin
        if (tb_we) mem[tb_waddr] <= tb_wdata;
        if (mem_we) begin
            mem[mem_addr[15:0]] <= mem_wdata;
            wr_log.push_back({mem_addr, mem_wdata});
        end
    end

    // ---------------- bookkeeping ----------------
    int total = 0;
    int bad   = 0;

    logic [31:0] job_a[$];
    logic [31:0] job_b[$];
    logic [31:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        tb_we    = 1'b1;
        tb_waddr = addr[15:0];
        tb_wdata = data;
        @(negedge clk);
        tb_we    = 1'b0;
    endtask

    // Reference: C[i] = low word of the 64-bit signed dot product of row i
    function automatic void model(input int m, input int n);
        longint acc;
        exp_q.delete();
        for (int i = 0; i < m; i++) begin
            acc = 0;
            for (int j = 0; j < n; j++)
                acc += longint'($signed(job_a[i*n+j])) * longint'($signed(job_b[j]));
            exp_q.push_back(acc[31:0]);
        end
    endfunction

    // Cycles busy stays high: 6 config cycles, each row ROW+MAC+WR_C
    // (ROW+WR_C only when N=0), then CLR and DONE.
    function automatic int exp_busy(input int m, input int n);
        return 6 + m * ((n == 0) ? 2 : 2 * n + 3) + 2;
    endfunction

    task automatic gen_random(input int m, input int n);
        job_a.delete();
        job_b.delete();
        for (int k = 0; k < m * n; k++) job_a.push_back($urandom);
        for (int k = 0; k < n; k++)     job_b.push_back($urandom);
    endtask

    task automatic load_data(input int m, input int n, input logic [31:0] ab,
                             input logic [31:0] bb, input logic [31:0] cb);
        for (int k = 0; k < m * n; k++) wr(ab + k, job_a[k]);
        for (int k = 0; k < n; k++)     wr(bb + k, job_b[k]);
        wr(32'h300, ab);
        wr(32'h400, bb);
        wr(32'h500, cb);
        wr(32'h600, m);
        wr(32'h700, n);
    endtask

    task automatic set_flag(input logic [31:0] val);
        wr_log.delete();
        wr(32'hB00, val);
    endtask

    task automatic finish_job(input string tag, input int m, input int n,
                              input logic [31:0] cb, input bit drop_en);
        int  k;
        int  busy_cnt;
        bit  seen;
        k = 0;
        while (!busy && k < 3) begin
            @(negedge clk);
            k++;
        end
        chk({tag, " busy_start"}, busy, 1);
        if (drop_en) en = 1'b0;
        busy_cnt = 1;
        seen = 0;
        for (int c = 0; c < 20000; c++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                break;
            end
            if (busy) busy_cnt++;
        end
        en = 1'b1;
        chk({tag, " done_seen"}, seen, 1);
        chk({tag, " busy_cycles"}, busy_cnt, exp_busy(m, n));
        chk({tag, " write_count"}, wr_log.size(), m + 1);
        for (int i = 0; i < m && i < wr_log.size(); i++) begin
            chk($sformatf("%s C[%0d] addr", tag, i), wr_log[i].addr, cb + i);
            chk($sformatf("%s C[%0d] data", tag, i), wr_log[i].data, exp_q[i]);
        end
        if (wr_log.size() == m + 1) begin
            chk({tag, " flag_clr addr"}, wr_log[m].addr, 32'hB00);
            chk({tag, " flag_clr data"}, wr_log[m].data, 0);
        end
        @(negedge clk);
        chk({tag, " done_width"}, done, 0);
        chk({tag, " busy_after"}, busy, 0);
    endtask

    // ---------------- vector table ----------------
    typedef struct packed {
        logic [31:0]       m;
        logic [31:0]       n;
        logic [5:0][31:0]  a;
        logic [2:0][31:0]  b;
        logic [1:0][31:0]  exp_c;
        logic [31:0]       flag;
    } vec_t;
    vec_t vecs[4];

    initial begin
        int cnt_we;
        int cnt_busy;
        int sz;
        int k;

        // basic 2x3
        vecs[0].m = 2; vecs[0].n = 3;
        vecs[0].a = {32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
        vecs[0].b = {32'hFFFF_FFFF, 32'd0, 32'd1};
        vecs[0].exp_c = {32'hFFFF_FFFE, 32'hFFFF_FFFE};
        vecs[0].flag = 32'h1;
        // signed overflow, flag with extra high bits set
        vecs[1].m = 1; vecs[1].n = 2;
        vecs[1].a = {128'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF};
        vecs[1].b = {32'd0, 32'd2, 32'd2};
        vecs[1].exp_c = {32'd0, 32'hFFFF_FFFC};
        vecs[1].flag = 32'h8000_0001;
        // M = 0
        vecs[2].m = 0; vecs[2].n = 3;
        vecs[2].a = '0;
        vecs[2].b = {32'd3, 32'd2, 32'd1};
        vecs[2].exp_c = '0;
        vecs[2].flag = 32'h1;
        // N = 0
        vecs[3].m = 2; vecs[3].n = 0;
        vecs[3].a = '0;
        vecs[3].b = '0;
        vecs[3].exp_c = '0;
        vecs[3].flag = 32'h1;

        // ---- reset state ----
        rst_n = 1'b0;
        en    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("reset mem_addr", mem_addr, 0);
        chk("reset mem_wdata", mem_wdata, 0);
        chk("reset mem_we", mem_we, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        wr(32'hB00, 32'h2);      // bit 0 clear: must not start a job
        rst_n = 1'b1;

        // ---- idle polling ----
        en = 1'b1;
        cnt_we = 0;
        cnt_busy = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (mem_we) cnt_we++;
            if (busy)   cnt_busy++;
        end
        chk("idle mem_we count", cnt_we, 0);
        chk("idle busy count", cnt_busy, 0);
        chk("idle poll addr", mem_addr, 32'hB00);

        // ---- table-driven jobs ----
        for (int v = 0; v < 4; v++) begin
            job_a.delete();
            job_b.delete();
            exp_q.delete();
            for (int i = 0; i < vecs[v].m * vecs[v].n; i++) job_a.push_back(vecs[v].a[i]);
            for (int j = 0; j < vecs[v].n; j++)             job_b.push_back(vecs[v].b[j]);
            for (int i = 0; i < vecs[v].m; i++)             exp_q.push_back(vecs[v].exp_c[i]);
            load_data(vecs[v].m, vecs[v].n, 32'h1000, 32'h2000, 32'h3000);
            set_flag(vecs[v].flag);
            finish_job($sformatf("vec%0d", v), vecs[v].m, vecs[v].n, 32'h3000, 1'b0);
        end

        // ---- random jobs vs reference model ----
        for (int r = 0; r < 6; r++) begin
            int m;
            int n;
            logic [31:0] ab;
            logic [31:0] bb;
            logic [31:0] cb;
            m  = $urandom_range(1, 4);
            n  = $urandom_range(0, 5);
            ab = 32'h8000 + $urandom_range(0, 255);
            bb = 32'h9000 + $urandom_range(0, 255);
            cb = 32'hA000 + $urandom_range(0, 255);
            gen_random(m, n);
            model(m, n);
            load_data(m, n, ab, bb, cb);
            set_flag({$urandom_range(0, 32'h7FFF_FFFF), 1'b1});
            finish_job($sformatf("rnd%0d", r), m, n, cb, r == 2);
        end

        // ---- back-to-back, config rewritten while the first job runs ----
        gen_random(4, 5);
        model(4, 5);
        load_data(4, 5, 32'h4000, 32'h4800, 32'h5000);
        set_flag(32'h1);
        fork
            finish_job("b2b1", 4, 5, 32'h5000, 1'b0);
            begin
                k = 0;
                while (!busy && k < 10) begin
                    @(negedge clk);
                    k++;
                end
                gen_random(2, 2);
                load_data(2, 2, 32'h6000, 32'h6800, 32'h7000);
            end
        join
        model(2, 2);
        set_flag(32'h1);
        finish_job("b2b2", 2, 2, 32'h7000, 1'b0);

        // ---- reset during row 1 ----
        job_a.delete();
        job_b.delete();
        for (int i = 1; i <= 6; i++) job_a.push_back(i);
        job_b.push_back(32'd1);
        job_b.push_back(32'd0);
        job_b.push_back(32'hFFFF_FFFF);
        exp_q.delete();
        exp_q.push_back(32'hFFFF_FFFE);
        exp_q.push_back(32'hFFFF_FFFE);
        load_data(2, 3, 32'h1000, 32'h2000, 32'h3000);
        set_flag(32'h1);
        k = 0;
        while (wr_log.size() < 1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("rst first C write", wr_log.size(), 1);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst mem_we", mem_we, 0);
        chk("rst busy", busy, 0);
        chk("rst mem_addr", mem_addr, 0);
        chk("rst mem_wdata", mem_wdata, 0);
        sz = wr_log.size();
        repeat (3) @(negedge clk);
        chk("rst no writes", wr_log.size(), sz);
        chk("rst flag kept", mem[16'hB00], 1);
        rst_n = 1'b1;
        wr_log.delete();
        finish_job("rerun", 2, 3, 32'h3000, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
